countdown_timer_nbit: RTL

//  Loadable N-bit down-counter/timer; counterpart of the free-running up counter_Nbit.

---
 rtl/countdown_timer_nbit_pkg.sv | 19 +
 rtl/countdown_timer_nbit_tick_gen.sv | 40 ++++
 rtl/countdown_timer_nbit.sv | 105 ++++++++++
 3 files changed

// File: rtl/countdown_timer_nbit_pkg.sv
// Shared types and legal-parameter limits for the countdown timer.
package countdown_timer_nbit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam int MIN_N        = 2;
  localparam int MIN_PRESCALE = 1;

  // Prescaler register width; a one-cycle prescale still keeps a 1-bit register.
  function automatic int presc_width(input int ps);
    return (ps > 1) ? $clog2(ps) : 1;
  endfunction

endpackage

// File: rtl/countdown_timer_nbit_tick_gen.sv
// Prescaler: asserts tick on the last enabled cycle of every PRESCALE-cycle window.
module countdown_timer_nbit_tick_gen
  import countdown_timer_nbit_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int PS = (PRESCALE < MIN_PRESCALE) ? MIN_PRESCALE : PRESCALE;
  localparam int PW = presc_width(PS);
  localparam logic [PW-1:0] LAST = PW'(PS - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign tick_o = en_i && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (clr_i) begin
      pre_d = '0;
    end else if (en_i) begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/countdown_timer_nbit.sv
// Loadable N-bit down-counter with prescaled decrement, done pulse and optional auto-reload.
module countdown_timer_nbit
  import countdown_timer_nbit_pkg::*;
#(
  parameter int N        = 4,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [N-1:0] load_value_i,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         auto_reload_i,
  output logic [N-1:0] count_o,
  output logic         busy_o,
  output logic         done_o
);

  if (N < MIN_N) begin : g_bad_n
    $error("countdown_timer_nbit: N below minimum");
  end

  timer_state_t state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] reload_q, reload_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         restart;
  logic         tick_en;
  logic         tick;

  // Stop and load both outrank the tick, so the prescaler must freeze on them too.
  assign tick_en = (state_q == RUN) && !stop_i && !load_i;

  countdown_timer_nbit_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (tick_en),
    .clr_i (load_i | restart),
    .tick_o(tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    restart  = 1'b0;

    if (load_i) begin
      count_d  = load_value_i;
      reload_d = load_value_i;
      state_d  = IDLE;
    end else if (stop_i) begin
      if (state_q == RUN) begin
        state_d = HOLD;
      end
    end else if (start_i && (state_q == IDLE || state_q == HOLD) && (count_q != '0)) begin
      state_d = RUN;
    end else if (start_i && (state_q == EXPIRED) && (reload_q != '0)) begin
      count_d = reload_q;
      restart = 1'b1;
      state_d = RUN;
    end else if (tick) begin
      if (count_q > N'(1)) begin
        count_d = count_q - N'(1);
      end else begin
        // Terminal count; also covers a zero count so the value never wraps.
        done_d = 1'b1;
        if (auto_reload_i) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = EXPIRED;
        end
      end
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign count_o = count_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
